// File: rtl/video_capture_pkg.sv
// Shared constants and helpers for the video_capture framebuffer writer:
// the reference raster timing, the FSM state encodings, the CRC-16-CCITT
// constants and the 3-3-2 pixel packing function.
package video_capture_pkg;

    // Reference raster: 320x240 active inside a 392x262 total.
    localparam int H_ACT = 320;
    localparam int V_ACT = 240;
    localparam int HFP   = 16;
    localparam int HS    = 32;
    localparam int HBP   = 24;
    localparam int VFP   = 3;
    localparam int VS    = 4;
    localparam int VBP   = 15;

    // Capture FSM encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // CRC-16-CCITT, MSB first.
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    // Truncate 8-bit RGB to one RRRGGGBB byte.
    function automatic logic [7:0] pack332(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16-CCITT step: folds one byte, MSB first, into a running
// CRC. Used by video_capture only when VIDEO_CAPTURE_CRC_EN is defined.
module crc16_ccitt_byte
    import video_capture_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    // Eight unrolled shift/xor steps of the polynomial divider.
    always_comb begin
        // NOTE: crc_next is assigned before any conditional update, so every
        // path drives it and no latch can be inferred.
        crc_next = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[15] ? ((crc_next << 1) ^ CRC_POLY) : (crc_next << 1);
        end
    end

endmodule

// File: rtl/video_capture.sv
// Framebuffer writer: samples an RGB raster on ce_pix strobes, writes each
// active pixel of a captured frame as a 3-3-2 byte to a dpram write port,
// measures line/frame geometry and reports lock.
// Optional feature macro: VIDEO_CAPTURE_CRC_EN adds frame_crc[15:0], a
// CRC-16-CCITT over the data bytes written in each frame.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int H      = H_ACT,
    parameter int V      = V_ACT,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_en,
    input  logic              ce_pix,
    input  logic              de,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic [7:0]        r,
    input  logic [7:0]        g,
    input  logic [7:0]        b,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              frame_done,
    output logic              overflow,
    output logic [9:0]        meas_h,
    output logic [9:0]        meas_v,
    output logic              locked
`ifdef VIDEO_CAPTURE_CRC_EN
    ,
    output logic [15:0]       frame_crc
`endif
);

    // One extra bit so the write pointer can sit at H*V even when H*V == 2**ADDR_W.
    localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(H * V);
    localparam logic [9:0]      H_EXP     = 10'(H);
    localparam logic [9:0]      V_EXP     = 10'(V);

    logic [1:0]      state;
    logic            vs_prev, de_prev;
    logic [ADDR_W:0] addr_next;
    logic [9:0]      h_cnt, v_cnt;
    logic [1:0]      match_cnt;

    logic            vs_rise, de_fall, frame_end, frame_start;
    logic            cap_active, do_write, ovf_hit, measuring;
    logic [ADDR_W:0] addr_base;
    logic [9:0]      h_inc, v_inc, meas_h_new, meas_v_new;
    logic [7:0]      pix_byte;

    // Horizontal sync and the dropped colour LSBs carry no information here.
    wire unused_ok = &{1'b0, h_sync, r[4:0], g[4:0], b[5:0]};

    // Event decode for the current clk; a frame boundary that restarts capture
    // rebases the address to 0 so a coincident active pixel lands at addr 0.
    always_comb begin
        vs_rise     = ce_pix & v_sync & ~vs_prev;
        de_fall     = ce_pix & ~de & de_prev;
        frame_end   = vs_rise & (state == ST_CAPTURE);
        frame_start = vs_rise & capture_en & ((state == ST_ARMED) | (state == ST_CAPTURE));
        cap_active  = ce_pix & (frame_start | ((state == ST_CAPTURE) & ~frame_end));
        addr_base   = frame_start ? '0 : addr_next;
        do_write    = cap_active & de & (addr_base < FRAME_PIX);
        ovf_hit     = cap_active & de & (addr_base >= FRAME_PIX);
        measuring   = ce_pix & (state != ST_IDLE);
        h_inc       = (h_cnt == 10'd1023) ? h_cnt : h_cnt + 10'd1;
        v_inc       = (v_cnt == 10'd1023) ? v_cnt : v_cnt + 10'd1;
        meas_h_new  = de_fall ? h_cnt : meas_h;
        meas_v_new  = de_fall ? v_inc : v_cnt;
        pix_byte    = pack332(r, g, b);
    end

    // Capture FSM: arm on capture_en, run frame-to-frame on v_sync edges.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignment so every always_ff
        // sees the pre-edge value of its neighbours.
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (capture_en) state <= ST_ARMED;
                ST_ARMED:   if (!capture_en) state <= ST_IDLE;
                            else if (vs_rise) state <= ST_CAPTURE;
                ST_CAPTURE: if (vs_rise && !capture_en) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Previous-sample registers for the v_sync and de edge detectors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev <= 1'b0;
            de_prev <= 1'b0;
        end else if (ce_pix) begin
            vs_prev <= v_sync;
            de_prev <= de;
        end
    end

    // Write path: one-clk wr strobe, bounded non-wrapping address, overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr         <= 1'b0;
            addr       <= '0;
            data       <= '0;
            addr_next  <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr         <= do_write;
            frame_done <= frame_end;
            addr_next  <= addr_base + (ADDR_W+1)'(do_write);
            if (do_write) begin
                addr <= addr_base[ADDR_W-1:0];
                data <= pix_byte;
            end
            if (frame_start)  overflow <= 1'b0;
            else if (ovf_hit) overflow <= 1'b1;
        end
    end

    // Geometry measurement and lock qualification, active outside IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            meas_h    <= '0;
            meas_v    <= '0;
            match_cnt <= '0;
        end else if (measuring) begin
            if (de_fall) begin
                meas_h <= h_cnt;
                h_cnt  <= '0;
            end else if (de) begin
                h_cnt <= h_inc;
            end
            if (vs_rise) begin
                meas_v <= meas_v_new;
                v_cnt  <= '0;
                if (meas_h_new == H_EXP && meas_v_new == V_EXP)
                    match_cnt <= (match_cnt == 2'd2) ? 2'd2 : match_cnt + 2'd1;
                else
                    match_cnt <= '0;
            end else if (de_fall) begin
                v_cnt <= v_inc;
            end
        end
    end

    assign locked = (match_cnt == 2'd2);

`ifdef VIDEO_CAPTURE_CRC_EN
    logic [15:0] crc_run, crc_base, crc_step;

    assign crc_base = frame_start ? CRC_INIT : crc_run;

    crc16_ccitt_byte u_crc (
        .crc      (crc_base),
        .data     (pix_byte),
        .crc_next (crc_step)
    );

    // Running CRC over written bytes; latched into frame_crc as the frame closes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_run   <= CRC_INIT;
            frame_crc <= '0;
        end else begin
            crc_run <= do_write ? crc_step : crc_base;
            if (frame_end) frame_crc <= crc_run;
        end
    end
`endif

endmodule

// File: tb/tb_video_capture.sv
// Self-checking bench for video_capture on a reduced 16x8 raster (ADDR_W=7,
// so H*V sits exactly at 2**ADDR_W). Frame-level vectors come from a table;
// arm, mid-frame capture_en drop and mid-frame reset are hand-written.
module tb_video_capture;

    localparam int TH    = 16;
    localparam int TV    = 8;
    localparam int TAW   = 7;
    localparam int BLANK = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           capture_en = 1'b0;
    logic           ce_pix = 1'b0;
    logic           de = 1'b0;
    logic           h_sync = 1'b1;
    logic           v_sync = 1'b0;
    logic [7:0]     r = '0, g = '0, b = '0;
    logic           wr;
    logic [TAW-1:0] addr;
    logic [7:0]     data;
    logic           frame_done, overflow, locked;
    logic [9:0]     meas_h, meas_v;
`ifdef VIDEO_CAPTURE_CRC_EN
    logic [15:0]    frame_crc;
`endif

    video_capture #(.H(TH), .V(TV), .ADDR_W(TAW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .capture_en (capture_en),
        .ce_pix     (ce_pix),
        .de         (de),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .r          (r),
        .g          (g),
        .b          (b),
        .wr         (wr),
        .addr       (addr),
        .data       (data),
        .frame_done (frame_done),
        .overflow   (overflow),
        .meas_h     (meas_h),
        .meas_v     (meas_v),
        .locked     (locked)
`ifdef VIDEO_CAPTURE_CRC_EN
        ,
        .frame_crc  (frame_crc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r, g, b;
        int         last_len;
        logic [7:0] exp_data;
        int         exp_writes;
        logic       exp_ovf;
        int         exp_meas_h;
        logic       exp_locked;
    } vec_t;

    vec_t vecs [5];

    int checks = 0, failures = 0;
    int wr_cnt = 0, exp_addr = 0, addr_err = 0, data_err = 0, fd_cnt = 0, fd_base = 0;
    logic [7:0] exp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial reference CRC over n copies of byte d.
    function automatic logic [15:0] crc_ref(input logic [7:0] d, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int j = 0; j < n; j++) begin
            for (int bi = 7; bi >= 0; bi--) begin
                logic fb;
                fb = c[15] ^ d[bi];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr) begin
            if (addr !== TAW'(exp_addr)) addr_err++;
            if (data !== exp_data) data_err++;
            exp_addr++;
            wr_cnt++;
        end
        if (frame_done) fd_cnt++;
    end

    // One pixel: a ce_pix sample followed by one clk without ce_pix.
    task automatic pix(input logic d, input logic hs, input logic vs,
                       input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
        de = d; h_sync = hs; v_sync = vs; r = pr; g = pg; b = pb; ce_pix = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic blank_line(input logic vs);
        for (int k = 0; k < TH + BLANK; k++) pix(1'b0, !(k >= 1 && k < 3), vs, 8'h00, 8'h00, 8'h00);
    endtask

    // Frame boundary: clear the write bookkeeping, then sync line and back porch.
    task automatic frame_start_seq();
        wr_cnt = 0; exp_addr = 0; addr_err = 0; data_err = 0;
        blank_line(1'b1);
        blank_line(1'b0);
    endtask

    task automatic active(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                          input int last_len, input int drop_line);
        for (int ln = 0; ln < TV; ln++) begin
            if (ln == drop_line) capture_en = 1'b0;
            for (int k = 0; k < ((ln == TV - 1) ? last_len : TH); k++) pix(1'b1, 1'b1, 1'b0, pr, pg, pb);
            for (int k = 0; k < BLANK; k++) pix(1'b0, !(k == 1 || k == 2), 1'b0, 8'h00, 8'h00, 8'h00);
        end
    endtask

    task automatic close_checks(input int i, input int base);
        check($sformatf("v%0d_frame_done", i), fd_cnt - base, 1);
        check($sformatf("v%0d_meas_v", i), meas_v, TV);
        check($sformatf("v%0d_locked", i), locked, vecs[i].exp_locked);
        check($sformatf("v%0d_ovf_cleared", i), overflow, 0);
`ifdef VIDEO_CAPTURE_CRC_EN
        check($sformatf("v%0d_crc", i), frame_crc, crc_ref(vecs[i].exp_data, vecs[i].exp_writes));
`endif
    endtask

    initial begin
        //             r      g      b      last_len data   writes     ovf   meas_h  locked
        vecs[0] = '{8'hFF, 8'h00, 8'h00, TH,     8'hE0, TH*TV,     1'b0, TH,     1'b0};
        vecs[1] = '{8'hE0, 8'hE0, 8'hC0, TH,     8'hFF, TH*TV,     1'b0, TH,     1'b1};
        vecs[2] = '{8'h12, 8'h34, 8'h56, TH - 1, 8'h05, TH*TV - 1, 1'b0, TH - 1, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 8'hC3, TH + 1, 8'hAB, TH*TV,     1'b1, TH + 1, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 8'h00, TH,     8'h00, TH*TV,     1'b0, TH,     1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", wr, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_meas_h", meas_h, 0);
        check("rst_meas_v", meas_v, 0);
        check("rst_locked", locked, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        capture_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven frames; each frame is closed by the next one's sync.
        for (int i = 0; i < 5; i++) begin
            fd_base = fd_cnt;
            frame_start_seq();
            if (i > 0) close_checks(i - 1, fd_base);
            else check("arm_no_frame_done", fd_cnt - fd_base, 0);
            exp_data = vecs[i].exp_data;
            active(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].last_len, -1);
            check($sformatf("v%0d_writes", i), wr_cnt, vecs[i].exp_writes);
            check($sformatf("v%0d_addr_seq_err", i), addr_err, 0);
            check($sformatf("v%0d_data_err", i), data_err, 0);
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].exp_ovf);
            check($sformatf("v%0d_meas_h", i), meas_h, vecs[i].exp_meas_h);
        end
        fd_base = fd_cnt;
        frame_start_seq();
        close_checks(4, fd_base);

        // capture_en dropped mid-frame: the frame still completes, then IDLE.
        exp_data = 8'h29;
        active(8'h20, 8'h40, 8'h40, TH, TV / 2);
        check("drop_writes", wr_cnt, TH * TV);
        check("drop_addr_seq_err", addr_err, 0);
        check("drop_data_err", data_err, 0);
        fd_base = fd_cnt;
        frame_start_seq();
        check("drop_frame_done", fd_cnt - fd_base, 1);
        check("drop_locked", locked, 1);
        active(8'h20, 8'h40, 8'h40, TH, -1);
        check("idle_no_writes", wr_cnt, 0);
        fd_base = fd_cnt;
        frame_start_seq();
        check("idle_no_frame_done", fd_cnt - fd_base, 0);

        // Asynchronous reset in the middle of a frame.
        capture_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame_start_seq();
        exp_data = 8'h1C;
        for (int k = 0; k < 10; k++) pix(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00);
        de = 1'b1; h_sync = 1'b1; v_sync = 1'b0; r = 8'h00; g = 8'hFF; b = 8'h00; ce_pix = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
        check("prerst_wr", wr, 1);
        check("prerst_addr", addr, 10);
        reset_n = 1'b0;
        de = 1'b0;
        #1;
        check("midrst_wr", wr, 0);
        check("midrst_addr", addr, 0);
        check("midrst_meas_h", meas_h, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frame_start_seq();
        active(8'h00, 8'hFF, 8'h00, TH, -1);
        check("postrst_writes", wr_cnt, TH * TV);
        check("postrst_addr_seq_err", addr_err, 0);
        check("postrst_data_err", data_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
